// File: rtl/af_cmd_pkg.sv
// Shared constants for the address-FIFO command issuer.
// Opcodes, FIFO entry field layout, timing limits and FSM states.
package af_cmd_pkg;

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_PRE  = 3'd1;
   localparam logic [2:0] OP_ACT  = 3'd2;
   localparam logic [2:0] OP_RD   = 3'd3;
   localparam logic [2:0] OP_WR   = 3'd4;
   localparam logic [2:0] OP_PREA = 3'd5;

   localparam int AF_W     = 29;
   localparam int ROW_LSB  = 15;
   localparam int ROW_W    = 14;
   localparam int BANK_LSB = 12;
   localparam int BANK_W   = 3;
   localparam int COL_LSB  = 3;
   localparam int COL_W    = 9;
   localparam int RANK_LSB = 1;
   localparam int RANK_W   = 2;
   localparam int RW_BIT   = 0;

   localparam int T_MIN = 1;
   localparam int T_MAX = 15;

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_PRE,
      S_ACT,
      S_RW,
      S_PREA,
      S_WAIT
   } state_e;

   // Counter load value; out-of-range timings are clamped.
   function automatic logic [3:0] wait_load(input int t);
      int tc;
      tc = t;
      if (tc < T_MIN) tc = T_MIN;
      if (tc > T_MAX) tc = T_MAX;
      return 4'(tc - 1);
   endfunction

endpackage

// File: rtl/af_open_row_table.sv
// Open-row table: 32 entries of {open, row} indexed by {rank,bank}.
// One combinational read port, one write port, clear-all of open bits.
module af_open_row_table
   import af_cmd_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [4:0]       rd_idx_i,
   output logic             rd_open_o,
   output logic [ROW_W-1:0] rd_row_o,
   input  logic             wr_en_i,
   input  logic [4:0]       wr_idx_i,
   input  logic             wr_open_i,
   input  logic [ROW_W-1:0] wr_row_i,
   input  logic             clr_all_i
);

   logic [31:0]      open_q;
   logic [ROW_W-1:0] row_q [32];

   assign rd_open_o = open_q[rd_idx_i];
   assign rd_row_o  = row_q[rd_idx_i];

   // Open bits: clear-all beats a single-entry write.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         open_q <= '0;
      end else if (clr_all_i) begin
         open_q <= '0;
      end else if (wr_en_i) begin
         open_q[wr_idx_i] <= wr_open_i;
      end
   end

   // Row storage only matters while the entry is open.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < 32; i++) row_q[i] <= '0;
      end else if (wr_en_i && wr_open_i) begin
         row_q[wr_idx_i] <= wr_row_i;
      end
   end

endmodule

// File: rtl/af_cmd_issue.sv
// Address-FIFO consumer issuing PRE/ACT/RD/WR/PREA to the DDR sequencer.
// Holds the FSM, the request register and the timing wait counter.
module af_cmd_issue
   import af_cmd_pkg::*;
#(
   parameter int T_RP  = 3,
   parameter int T_RCD = 3
) (
   input  logic        Clk,
   input  logic        Reset_n,
   input  logic [28:0] AfRD,
   input  logic        AfEmpty,
   output logic        AfREn,
   output logic        CmdValid,
   input  logic        CmdReady,
   output logic [2:0]  CmdOp,
   output logic [1:0]  CmdRank,
   output logic [2:0]  CmdBank,
   output logic [13:0] CmdAddr,
   input  logic        RefReq,
   output logic        RefAck
);

   state_e          state_q, state_d;
   state_e          tgt_q, tgt_d;
   logic [AF_W-1:0] req_q, req_d;
   logic [3:0]      cnt_q, cnt_d;
   logic            ack_q, ack_d;

   logic [ROW_W-1:0]  req_row;
   logic [BANK_W-1:0] req_bank;
   logic [COL_W-1:0]  req_col;
   logic [RANK_W-1:0] req_rank;
   logic              req_rd;

   logic             tb_open;
   logic [ROW_W-1:0] tb_row;
   logic             tb_we;
   logic             tb_wopen;
   logic             tb_clr;

   assign req_row  = req_q[ROW_LSB +: ROW_W];
   assign req_bank = req_q[BANK_LSB +: BANK_W];
   assign req_col  = req_q[COL_LSB +: COL_W];
   assign req_rank = req_q[RANK_LSB +: RANK_W];
   assign req_rd   = req_q[RW_BIT];
   assign RefAck   = ack_q;

   af_open_row_table u_tbl (
      .clk_i     (Clk),
      .rst_ni    (Reset_n),
      .rd_idx_i  ({req_rank, req_bank}),
      .rd_open_o (tb_open),
      .rd_row_o  (tb_row),
      .wr_en_i   (tb_we),
      .wr_idx_i  ({req_rank, req_bank}),
      .wr_open_i (tb_wopen),
      .wr_row_i  (req_row),
      .clr_all_i (tb_clr)
   );

   // State, request, counter and refresh-ack registers.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         tgt_q   <= S_IDLE;
         req_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
      end
   end

   // Next state and command outputs; Cmd* derive only from state_q/req_q so they hold while stalled.
   always_comb begin
      state_d  = state_q;
      tgt_d    = tgt_q;
      req_d    = req_q;
      cnt_d    = cnt_q;
      ack_d    = 1'b0;
      tb_we    = 1'b0;
      tb_wopen = 1'b0;
      tb_clr   = 1'b0;
      AfREn    = 1'b0;
      CmdValid = 1'b0;
      CmdOp    = OP_NOP;
      CmdRank  = '0;
      CmdBank  = '0;
      CmdAddr  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (RefReq) begin
               state_d = S_PREA;
            end else if (!AfEmpty) begin
               req_d   = AfRD;
               state_d = S_CHECK;
            end
         end
         S_CHECK: begin
            if (tb_open && (tb_row == req_row)) state_d = S_RW;
            else if (tb_open)                   state_d = S_PRE;
            else                                state_d = S_ACT;
         end
         S_PRE: begin
            CmdValid = 1'b1;
            CmdOp    = OP_PRE;
            CmdRank  = req_rank;
            CmdBank  = req_bank;
            if (CmdReady) begin
               tb_we   = 1'b1;
               cnt_d   = wait_load(T_RP);
               tgt_d   = S_ACT;
               state_d = S_WAIT;
            end
         end
         S_ACT: begin
            CmdValid = 1'b1;
            CmdOp    = OP_ACT;
            CmdRank  = req_rank;
            CmdBank  = req_bank;
            CmdAddr  = req_row;
            if (CmdReady) begin
               tb_we    = 1'b1;
               tb_wopen = 1'b1;
               cnt_d    = wait_load(T_RCD);
               tgt_d    = S_RW;
               state_d  = S_WAIT;
            end
         end
         S_RW: begin
            CmdValid = 1'b1;
            CmdOp    = req_rd ? OP_RD : OP_WR;
            CmdRank  = req_rank;
            CmdBank  = req_bank;
            CmdAddr  = {5'b0, req_col};
            if (CmdReady) begin
               AfREn   = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_PREA: begin
            CmdValid = 1'b1;
            CmdOp    = OP_PREA;
            if (CmdReady) begin
               tb_clr  = 1'b1;
               ack_d   = 1'b1;
               cnt_d   = wait_load(T_RP);
               tgt_d   = S_IDLE;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) state_d = tgt_q;
            else               cnt_d   = cnt_q - 4'd1;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_af_cmd_issue.sv
// Directed bench for af_cmd_issue.
// Request vectors with expected command sequences, plus refresh and stall cases.
module tb_af_cmd_issue;

   localparam int T_RP  = 3;
   localparam int T_RCD = 3;

   localparam logic [2:0] NOP  = 3'd0;
   localparam logic [2:0] PRE  = 3'd1;
   localparam logic [2:0] ACT  = 3'd2;
   localparam logic [2:0] RD   = 3'd3;
   localparam logic [2:0] WR   = 3'd4;
   localparam logic [2:0] PREA = 3'd5;

   logic        Clk;
   logic        Reset_n;
   logic [28:0] AfRD;
   logic        AfEmpty;
   logic        AfREn;
   logic        CmdValid;
   logic        CmdReady;
   logic [2:0]  CmdOp;
   logic [1:0]  CmdRank;
   logic [2:0]  CmdBank;
   logic [13:0] CmdAddr;
   logic        RefReq;
   logic        RefAck;

   af_cmd_issue #(.T_RP(T_RP), .T_RCD(T_RCD)) dut (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .AfRD     (AfRD),
      .AfEmpty  (AfEmpty),
      .AfREn    (AfREn),
      .CmdValid (CmdValid),
      .CmdReady (CmdReady),
      .CmdOp    (CmdOp),
      .CmdRank  (CmdRank),
      .CmdBank  (CmdBank),
      .CmdAddr  (CmdAddr),
      .RefReq   (RefReq),
      .RefAck   (RefAck)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct packed {
      logic [2:0]  op;
      logic [1:0]  rank;
      logic [2:0]  bank;
      logic [13:0] addr;
      logic [31:0] cyc;
   } cmd_t;

   typedef struct {
      logic [28:0]      rd;
      logic             refr;
      logic             stall;
      int               n;
      logic [1:0]       rank;
      logic [2:0]       bank;
      logic [2:0][2:0]  op;
      logic [2:0][13:0] addr;
   } vec_t;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [31:0] cyc = 0;
   cmd_t        cmd_q[$];
   int          pops = 0;
   int          acks = 0;
   logic [31:0] ack_cyc = 0;
   vec_t        vt[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(posedge Clk) cyc <= cyc + 1;

   always @(negedge Clk) begin
      if (Reset_n && CmdValid && CmdReady)
         cmd_q.push_back('{CmdOp, CmdRank, CmdBank, CmdAddr, cyc});
      if (Reset_n && AfREn) begin
         pops++;
         chk("pop_while_empty", {31'd0, AfEmpty}, 32'd0);
      end
      if (Reset_n && RefAck) begin
         acks++;
         ack_cyc = cyc;
      end
   end

   task automatic run_vec(input int i);
      vec_t v;
      bit   done;
      cmd_t snap;
      v = vt[i];
      cmd_q.delete();
      pops = 0;
      acks = 0;
      if (v.refr) begin
         @(negedge Clk);
         RefReq = 1'b1;
         done = 0;
         for (int k = 0; k < 100 && !done; k++) begin
            @(negedge Clk);
            if (acks > 0) done = 1;
         end
         RefReq = 1'b0;
         chk("refack_seen", {31'd0, done}, 32'd1);
         repeat (10) @(negedge Clk);
         chk("prea_count", cmd_q.size(), 32'd1);
         chk("refack_count", acks, 32'd1);
         if (cmd_q.size() > 0) begin
            chk("prea_op", {29'd0, cmd_q[0].op}, {29'd0, PREA});
            chk("prea_fields", {cmd_q[0].rank, cmd_q[0].bank, cmd_q[0].addr}, 32'd0);
            chk("refack_timing", ack_cyc - cmd_q[0].cyc, 32'd1);
         end
         cmd_q.delete();
      end
      @(negedge Clk);
      if (v.stall) CmdReady = 1'b0;
      AfRD    = v.rd;
      AfEmpty = 1'b0;
      if (v.stall) begin
         done = 0;
         for (int k = 0; k < 50 && !done; k++) begin
            @(negedge Clk);
            if (CmdValid) done = 1;
         end
         chk("stall_valid_seen", {31'd0, done}, 32'd1);
         snap = '{CmdOp, CmdRank, CmdBank, CmdAddr, 32'd0};
         chk("stall_op", {29'd0, snap.op}, {29'd0, ACT});
         for (int k = 0; k < 10; k++) begin
            @(negedge Clk);
            chk("stall_hold", {CmdValid, AfREn, CmdOp, CmdRank, CmdBank, CmdAddr},
                {1'b1, 1'b0, snap.op, snap.rank, snap.bank, snap.addr});
         end
         CmdReady = 1'b1;
      end
      done = 0;
      for (int k = 0; k < 200 && !done; k++) begin
         @(negedge Clk);
         if (AfREn) done = 1;
      end
      chk("pop_seen", {31'd0, done}, 32'd1);
      @(posedge Clk);
      #1 AfEmpty = 1'b1;
      repeat (3) @(negedge Clk);
      chk("pop_count", pops, 32'd1);
      chk("cmd_count", cmd_q.size(), v.n);
      for (int k = 0; k < v.n && k < cmd_q.size(); k++) begin
         chk("cmd_op", {29'd0, cmd_q[k].op}, {29'd0, v.op[k]});
         chk("cmd_rank", {30'd0, cmd_q[k].rank}, {30'd0, v.rank});
         chk("cmd_bank", {29'd0, cmd_q[k].bank}, {29'd0, v.bank});
         chk("cmd_addr", {18'd0, cmd_q[k].addr}, {18'd0, v.addr[k]});
         if (k > 0) begin
            int need;
            need = (v.op[k-1] == PRE) ? T_RP : T_RCD;
            chk("cmd_gap_ok", {31'd0, ((cmd_q[k].cyc - cmd_q[k-1].cyc) >= 32'(need))}, 32'd1);
         end
      end
   endtask

   initial begin
      vt[0] = '{29'h091A083, 1'b0, 1'b0, 2, 2'd1, 3'd2,
                {NOP, RD, ACT}, {14'h0, 14'h0010, 14'h0123}};
      vt[1] = '{29'h091A102, 1'b0, 1'b0, 1, 2'd1, 3'd2,
                {NOP, NOP, WR}, {14'h0, 14'h0, 14'h0020}};
      vt[2] = '{29'h22B2003, 1'b0, 1'b0, 3, 2'd1, 3'd2,
                {RD, ACT, PRE}, {14'h0000, 14'h0456, 14'h0000}};
      vt[3] = '{29'h1FFFFFFE, 1'b0, 1'b0, 2, 2'd3, 3'd7,
                {NOP, WR, ACT}, {14'h0, 14'h01FF, 14'h3FFF}};
      vt[4] = '{29'h22B202A, 1'b0, 1'b0, 1, 2'd1, 3'd2,
                {NOP, NOP, WR}, {14'h0, 14'h0, 14'h0005}};
      vt[5] = '{29'h22B202A, 1'b1, 1'b0, 2, 2'd1, 3'd2,
                {NOP, WR, ACT}, {14'h0, 14'h0005, 14'h0456}};

      Reset_n  = 1'b0;
      AfRD     = vt[0].rd;
      AfEmpty  = 1'b0;
      CmdReady = 1'b1;
      RefReq   = 1'b0;
      repeat (3) @(negedge Clk);
      chk("rst_cmdvalid", {31'd0, CmdValid}, 32'd0);
      chk("rst_afren", {31'd0, AfREn}, 32'd0);
      chk("rst_refack", {31'd0, RefAck}, 32'd0);
      chk("rst_cmdop", {29'd0, CmdOp}, {29'd0, NOP});
      chk("rst_fields", {CmdRank, CmdBank, CmdAddr}, 32'd0);
      Reset_n = 1'b1;

      for (int i = 0; i < 6; i++) run_vec(i);

      vt[0] = '{29'h0559019, 1'b0, 1'b1, 2, 2'd0, 3'd1,
                {NOP, RD, ACT}, {14'h0, 14'h0003, 14'h00AB}};
      run_vec(0);

      cmd_q.delete();
      AfEmpty = 1'b1;
      repeat (20) @(negedge Clk);
      chk("idle_empty_no_cmd", cmd_q.size(), 32'd0);
      chk("idle_empty_valid", {31'd0, CmdValid}, 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
